// File: rtl/axi_pattern_burst_writer_pkg.sv
// Shared constants for the AXI pattern burst writer.
// Response codes, burst type, FSM encodings and 4KB helper.
package axi_pattern_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // Beats left before the next 4KB page, given the page offset.
  function automatic logic [12:0] beats_to_4k(
    input logic [11:0] off,
    input int unsigned lg
  );
    beats_to_4k = (13'h1000 - {1'b0, off}) >> lg;
  endfunction

endpackage

// File: rtl/axi_pattern_burst_writer_if.sv
// AXI4 write-only bus between pattern writer and memory slave.
// Master drives AW/W and bready; slave drives readies and B.
interface axi_pattern_burst_writer_if #(
  parameter int ADDR_W = 44,
  parameter int DATA_W = 128
);

  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst,
    output awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst,
    input  awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_pattern_gen.sv
// Beat data generator: constant pattern or per-lane byte address.
// Lane k of an address-pattern beat carries beat address + 4k.
module axi_pattern_gen #(
  parameter int DATA_W = 128
) (
  input  logic              mode_i,
  input  logic [DATA_W-1:0] pattern_i,
  input  logic [31:0]       addr_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      data_o[32*k +: 32] = mode_i ?
        addr_i + 32'(4 * k) :
        pattern_i[32*k +: 32];
    end
  end

endmodule

// File: rtl/axi_pattern_burst_writer.sv
// AXI4 write master filling memory with a deterministic pattern.
// One outstanding 4KB-safe INCR burst at a time; sticky error on bad BRESP.
module axi_pattern_burst_writer
  import axi_pattern_pkg::*;
#(
  parameter int ADDR_W    = 44,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_beats,
  input  logic              pattern_mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_resp,
  axi_pattern_burst_writer_if.master m_axi
);

  localparam int BPB = DATA_W / 8;
  localparam int LG  = $clog2(BPB);
  localparam logic [ADDR_W-1:0] AMASK =
    ~ADDR_W'(BPB - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        beat_q, beat_d;
  logic [31:0]       baddr_q, baddr_d;
  logic              error_q, error_d;
  logic [1:0]        err_resp_q, err_resp_d;

  logic [12:0] b4k;
  logic [8:0]  len_c;
  logic        last;

  assign b4k  = beats_to_4k(addr_q[11:0], LG);
  assign last = (beat_q == len_q - 9'd1);

  // Burst length: remaining beats, MAX_BURST and 4KB page limit.
  always_comb begin
    len_c = 9'(MAX_BURST);
    if (b4k < 13'(len_c))
      len_c = b4k[8:0];
    if (rem_q < CNT_W'(len_c))
      len_c = rem_q[8:0];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    len_d      = len_q;
    beat_d     = beat_q;
    baddr_d    = baddr_q;
    error_d    = error_q;
    err_resp_d = err_resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr & AMASK;
          rem_d      = num_beats;
          mode_d     = pattern_mode;
          pat_d      = pattern;
          error_d    = 1'b0;
          err_resp_d = AXI_RESP_OKAY;
          state_d    = (num_beats == '0) ?
                       ST_FIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.awready) begin
          len_d   = len_c;
          beat_d  = 9'd0;
          baddr_d = addr_q[31:0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_axi.wready) begin
          baddr_d = baddr_q + 32'(BPB);
          beat_d  = beat_q + 9'd1;
          if (last)
            state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY) begin
            if (!error_q) begin
              error_d    = 1'b1;
              err_resp_d = m_axi.bresp;
            end
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_q +
                      (ADDR_W'(len_q) << LG);
            rem_d   = rem_q - CNT_W'(len_q);
            state_d = (rem_q == CNT_W'(len_q)) ?
                      ST_FIN : ST_ADDR;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      pat_q      <= '0;
      len_q      <= 9'd0;
      beat_q     <= 9'd0;
      baddr_q    <= 32'd0;
      error_q    <= 1'b0;
      err_resp_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      baddr_q    <= baddr_d;
      error_q    <= error_d;
      err_resp_q <= err_resp_d;
    end
  end

  axi_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_gen (
    .mode_i    (mode_q),
    .pattern_i (pat_q),
    .addr_i    (baddr_q),
    .data_o    (m_axi.wdata)
  );

  assign m_axi.awvalid = (state_q == ST_ADDR);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = m_axi.awvalid ?
                         8'(len_c - 9'd1) : 8'd0;
  assign m_axi.awsize  = 3'(LG);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awcache = 4'hF;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state_q == ST_DATA);
  assign m_axi.wlast   = m_axi.wvalid && last;
  assign m_axi.bready  = (state_q == ST_RESP);

  assign busy     = (state_q == ST_ADDR) ||
                    (state_q == ST_DATA) ||
                    (state_q == ST_RESP);
  assign done     = (state_q == ST_FIN);
  assign error    = error_q;
  assign err_resp = err_resp_q;

endmodule

// File: tb/tb_axi_pattern_burst_writer.sv
// Directed bench for axi_pattern_burst_writer with a memory slave model.
// Slave stalls randomly; monitor records bursts and beats for checking.
module tb_axi_pattern_burst_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic [43:0]  base_addr;
  logic [15:0]  num_beats;
  logic         pattern_mode;
  logic [127:0] pattern;
  logic         busy, done, error;
  logic [1:0]   err_resp;

  axi_pattern_burst_writer_if #(
    .ADDR_W (44),
    .DATA_W (128)
  ) axi ();

  axi_pattern_burst_writer #(
    .ADDR_W    (44),
    .DATA_W    (128),
    .MAX_BURST (16),
    .CNT_W     (16)
  ) dut (
    .ACLK         (clk),
    .ARESETn      (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_beats    (num_beats),
    .pattern_mode (pattern_mode),
    .pattern      (pattern),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_resp     (err_resp),
    .m_axi        (axi)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  logic [43:0]  aw_a[$];
  logic [7:0]   aw_l[$];
  logic [43:0]  wr_a[$];
  logic [127:0] mem [logic [43:0]];
  int w_burst, w_beat, b_pend, b_cnt;
  int done_cnt, hs_cnt, err_burst;
  bit stall;
  bit aw_hold, w_hold;
  logic [51:0]  aw_hv;
  logic [128:0] w_hv;
  logic [43:0]  mon_a;
  int cyc;

  task automatic clear_bk();
    aw_a.delete();
    aw_l.delete();
    wr_a.delete();
    mem.delete();
    w_burst  = 0;
    w_beat   = 0;
    b_pend   = 0;
    b_cnt    = 0;
    done_cnt = 0;
    hs_cnt   = 0;
    aw_hold  = 0;
    w_hold   = 0;
  endtask

  function automatic logic [127:0] exp_beat(
    input logic m, input logic [127:0] p,
    input logic [43:0] a);
    logic [31:0] x;
    x = a[31:0];
    return m ? {x + 32'd12, x + 32'd8,
                x + 32'd4, x} : p;
  endfunction

  // Slave drivers: ready for one cycle, then stall 0-5 cycles.
  initial begin
    int aw_st, w_st, b_st;
    aw_st = 0; w_st = 0; b_st = 0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (aw_st > 0) begin
        axi.awready = 1'b0;
        aw_st--;
      end else begin
        axi.awready = 1'b1;
        aw_st = stall ? $urandom_range(0, 5) : 0;
      end
      if (w_st > 0) begin
        axi.wready = 1'b0;
        w_st--;
      end else begin
        axi.wready = 1'b1;
        w_st = stall ? $urandom_range(0, 5) : 0;
      end
      if (axi.bvalid) begin
        if (b_pend == 0) axi.bvalid = 1'b0;
      end else if (b_pend > 0) begin
        if (b_st > 0) b_st--;
        else begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_cnt == err_burst) ?
                       2'b10 : 2'b00;
          b_st = stall ? $urandom_range(0, 5) : 0;
        end
      end
    end
  end

  // Monitor: values at negedge are those taken at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_hold)
        chk("aw_stable",
            {axi.awvalid, axi.awaddr, axi.awlen},
            {1'b1, aw_hv});
      if (w_hold)
        chk("w_stable",
            {axi.wvalid, axi.wlast, axi.wdata},
            {1'b1, w_hv});
      aw_hold = axi.awvalid && !axi.awready;
      aw_hv   = {axi.awaddr, axi.awlen};
      w_hold  = axi.wvalid && !axi.wready;
      w_hv    = {axi.wlast, axi.wdata};
      if (axi.awvalid)
        chk("one_outstanding",
            (b_pend == 0 && w_burst == aw_a.size()), 1);
      if (axi.awvalid && axi.awready) begin
        chk("aw_fixed",
            {axi.awsize, axi.awburst,
             axi.awcache, axi.awprot},
            {3'd4, 2'b01, 4'hF, 3'd0});
        aw_a.push_back(axi.awaddr);
        aw_l.push_back(axi.awlen);
        hs_cnt++;
      end
      if (axi.wvalid)
        chk("w_after_aw", (w_burst < aw_a.size()), 1);
      if (axi.wvalid && axi.wready &&
          w_burst < aw_a.size()) begin
        chk("wstrb", axi.wstrb, 16'hFFFF);
        mon_a = aw_a[w_burst] + 44'(16 * w_beat);
        mem[mon_a] = axi.wdata;
        wr_a.push_back(mon_a);
        chk("wlast", axi.wlast,
            (w_beat == int'(aw_l[w_burst])));
        if (axi.wlast) begin
          w_burst++;
          w_beat = 0;
          b_pend++;
        end else begin
          w_beat++;
        end
        hs_cnt++;
      end
      if (axi.bvalid && axi.bready) begin
        b_pend--;
        b_cnt++;
        hs_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run(input logic [43:0] base,
                     input logic [15:0] n,
                     input logic m,
                     input logic [127:0] p,
                     input int eb,
                     input bit st,
                     input int n_wr,
                     output int c);
    clear_bk();
    err_burst = eb;
    stall     = st;
    @(posedge clk);
    #1;
    start        = 1'b1;
    base_addr    = base;
    num_beats    = n;
    pattern_mode = m;
    pattern      = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 1;
    chk("start_lat", {busy, axi.awvalid},
        (n != 0) ? 2'b11 : 2'b00);
    chk("err_clr", {error, err_resp}, 3'b000);
    while (!done && c < 4000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("post_done", {done, busy}, 2'b00);
    chk("nbeats", wr_a.size(), n_wr);
    for (int i = 0; i < wr_a.size(); i++) begin
      chk("waddr", wr_a[i],
          (base & ~44'hF) + 44'(16 * i));
      chk("wdata", mem[wr_a[i]],
          exp_beat(m, p, wr_a[i]));
    end
  endtask

  logic [43:0] e_a[3];
  logic [7:0]  e_l[3];

  initial begin
    start        = 1'b0;
    base_addr    = '0;
    num_beats    = '0;
    pattern_mode = 1'b0;
    pattern      = '0;
    stall        = 0;
    err_burst    = -1;
    clear_bk();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, error, err_resp}, 0);
    chk("rst_axi",
        {axi.awvalid, axi.wvalid, axi.bready,
         axi.wlast, axi.awaddr}, 0);
    chk("rst_wdata", axi.wdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(44'h8000_0000, 16'd4, 1'b0,
        128'hDEADBEAF12345678AABBCCDD11223344,
        -1, 0, 4, cyc);
    chk("t1_naw", aw_a.size(), 1);
    chk("t1_awaddr", aw_a[0], 44'h8000_0000);
    chk("t1_awlen", aw_l[0], 8'd3);
    chk("t1_err", error, 0);

    run(44'h0, 16'd40, 1'b1, '0, -1, 0, 40, cyc);
    e_a = '{44'h000, 44'h100, 44'h200};
    e_l = '{8'd15, 8'd15, 8'd7};
    chk("t2_naw", aw_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_awaddr", aw_a[i], e_a[i]);
      chk("t2_awlen", aw_l[i], e_l[i]);
    end
    chk("t2_beat10", mem[44'h10],
        128'h0000001C_00000018_00000014_00000010);

    run(44'hFC0, 16'd8, 1'b1, '0, -1, 0, 8, cyc);
    chk("t3_naw", aw_a.size(), 2);
    chk("t3_aw0", {aw_a[0], aw_l[0]}, {44'hFC0, 8'd3});
    chk("t3_aw1", {aw_a[1], aw_l[1]}, {44'h1000, 8'd3});

    run(44'h10F, 16'd2, 1'b1, '0, -1, 0, 2, cyc);
    chk("t3b_aw", {aw_a[0], aw_l[0]}, {44'h100, 8'd1});
    chk("t3b_beat", mem[44'h110],
        128'h0000011C_00000118_00000114_00000110);

    run(44'h0, 16'd48, 1'b1, '0, 1, 0, 32, cyc);
    chk("t4_naw", aw_a.size(), 2);
    chk("t4_err", {error, err_resp}, 3'b110);
    chk("t4_nb", b_cnt, 2);

    run(44'h2000, 16'd64, 1'b1, '0, -1, 1, 64, cyc);
    chk("t5_naw", aw_a.size(), 4);
    for (int i = 0; i < aw_a.size(); i++)
      chk("t5_aw", {aw_a[i], aw_l[i]},
          {44'h2000 + 44'(256 * i), 8'd15});
    chk("t5_err", error, 0);

    run(44'h500, 16'd0, 1'b0, '0, -1, 0, 0, cyc);
    chk("t6_lat", cyc, 1);
    chk("t6_hs", hs_cnt, 0);

    clear_bk();
    stall = 1;
    @(posedge clk);
    #1;
    start        = 1'b1;
    base_addr    = 44'h4000;
    num_beats    = 16'd32;
    pattern_mode = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!axi.wvalid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t7_in_data", axi.wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_async",
        {axi.awvalid, axi.wvalid, axi.bready,
         busy, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    stall = 0;
    rst_n = 1'b1;
    clear_bk();
    repeat (20) @(posedge clk);
    #1;
    chk("t7_quiet", hs_cnt, 0);
    chk("t7_idle", {busy, axi.awvalid, axi.wvalid}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
